// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter.
// Each producer has a one-entry holding slot. Full slots are granted the single
// register-file write port in round-robin order, and the write beat is registered.
module fp_wb_arbiter #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*5-1:0]      src_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [SRC_W-1:0]          rf_wsrc,
    output logic                      wb_busy
);

    localparam int unsigned NSRC = NUM_SRC;

    logic [NUM_SRC-1:0]             full;
    logic [NUM_SRC-1:0][4:0]        slot_addr;
    logic [NUM_SRC-1:0][DATA_W-1:0] slot_data;
    logic [SRC_W-1:0]               rr_ptr;

    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] accept;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   rr_next;
    logic               hit_hi;
    logic               hit_lo;
    logic [SRC_W-1:0]   idx_hi;
    logic [SRC_W-1:0]   idx_lo;

    // Round-robin search. The first full slot at or above rr_ptr wins.
    // If there is none, the search wraps and the lowest full slot wins.
    // This gives the same result as a modulo scan but avoids out-of-range indices.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            if (full[j]) begin
                if (!hit_lo) begin
                    hit_lo = 1'b1;
                    idx_lo = SRC_W'(j);
                end
                if (!hit_hi && (j >= 32'(rr_ptr))) begin
                    hit_hi = 1'b1;
                    idx_hi = SRC_W'(j);
                end
            end
        end
        grant_any = hit_lo;
        grant_idx = hit_hi ? idx_hi : idx_lo;
        grant     = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            grant[j] = grant_any && (32'(grant_idx) == j);
        end
        rr_next = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end

    // A source is ready when its slot is empty or is being drained this cycle.
    // A beat addressed to register 0 completes its handshake but does not load the slot.
    always_comb begin
        src_ready = ~full | grant;
        wb_busy   = |full;
        accept    = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            accept[i] = src_valid[i] && src_ready[i] && (src_waddr[i*5 +: 5] != 5'd0);
        end
    end

    // Slot occupancy, round-robin pointer and the registered write beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= '0;
            rr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_wsrc  <= '0;
        end else begin
            full <= accept | (full & ~grant);
            if (grant_any) begin
                rf_we    <= 1'b1;
                rf_waddr <= slot_addr[grant_idx];
                rf_wdata <= slot_data[grant_idx];
                rf_wsrc  <= grant_idx;
                rr_ptr   <= rr_next;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // Slot payload. It is only meaningful while the matching full bit is set.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
                slot_addr[i] <= src_waddr[i*5 +: 5];
                slot_data[i] <= src_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Testbench for fp_wb_arbiter.
// A reference model keeps one queue per source and applies the round-robin rule with modulo arithmetic.
module tb_fp_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N*5-1:0]  src_waddr = '0;
    logic [N*DW-1:0] src_wdata = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [SW-1:0]   rf_wsrc;
    logic            wb_busy;

    fp_wb_arbiter #(.DATA_W(DW), .NUM_SRC(N), .SRC_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_waddr (src_waddr),
        .src_wdata (src_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_wsrc   (rf_wsrc),
        .wb_busy   (wb_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } beat_t;

    // Reference model state
    beat_t         q [N][$];
    int            ptr = 0;
    logic          exp_we = 1'b0;
    logic [4:0]    exp_waddr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_wsrc = '0;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  obs_ready;
    logic [N-1:0]  acc = '0;
    logic          exp_busy;
    logic          obs_busy;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int cyc = 0;

    task automatic set_src(input int i, input logic [4:0] a, input logic [DW-1:0] d);
        src_waddr[i*5 +: 5]   = a;
        src_wdata[i*DW +: DW] = d;
    endtask

    task automatic rand_beat(input int i);
        logic [4:0] a;
        a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        set_src(i, a, DW'($urandom));
    endtask

    // Sample combinational outputs at the falling edge, advance the model,
    // then let the rising edge happen and settle.
    task automatic tick();
        int    g;
        beat_t e;
        @(negedge clk);
        cyc++;
        obs_ready = src_ready;
        obs_busy  = wb_busy;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && q[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
        end
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_ready[i] = (q[i].size() == 0) || (g == i);
            if (q[i].size() > 0) exp_busy = 1'b1;
        end
        acc = '0;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ptr       = 0;
            exp_we    = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            exp_wsrc  = '0;
        end else begin
            if (g >= 0) begin
                e         = q[g].pop_front();
                exp_we    = 1'b1;
                exp_waddr = e.a;
                exp_wdata = e.d;
                exp_wsrc  = SW'(g);
                ptr       = (g + 1) % N;
            end else begin
                exp_we = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && exp_ready[i]) begin
                    acc[i] = 1'b1;
                    if (src_waddr[i*5 +: 5] != 5'd0)
                        q[i].push_back('{a: src_waddr[i*5 +: 5], d: src_wdata[i*DW +: DW]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        src_valid = 3'b111;
        for (int i = 0; i < N; i++) set_src(i, 5'(i + 1), DW'(16'h1000 + i));
        for (int c = 0; c < 3; c++) begin
            tick();
            cmp_cnt++;
            if (rf_we !== 1'b0) begin
                mis_cnt++;
                $display("FAIL reset_we c=%0d got %b exp 0", c, rf_we);
            end
            cmp_cnt++;
            if (obs_busy !== 1'b0) begin
                mis_cnt++;
                $display("FAIL reset_busy c=%0d got %b exp 0", c, obs_busy);
            end
        end
        cmp_cnt++;
        if (rf_waddr !== 5'd0 || rf_wdata !== '0 || rf_wsrc !== '0) begin
            mis_cnt++;
            $display("FAIL reset_regs got a=%0d d=%h s=%0d exp 0/0/0", rf_waddr, rf_wdata, rf_wsrc);
        end
        rst_n     = 1'b1;
        src_valid = '0;
        tick();
        cmp_cnt++;
        if (obs_ready !== 3'b111) begin
            mis_cnt++;
            $display("FAIL reset_ready got %b exp 111", obs_ready);
        end
    endtask

    task automatic test_single_beat();
        src_valid = 3'b001;
        set_src(0, 5'd5, 16'h3C00);
        tick();
        cmp_cnt++;
        if (obs_ready[0] !== 1'b1 || rf_we !== 1'b0) begin
            mis_cnt++;
            $display("FAIL single_accept got ready=%b we=%b exp 1/0", obs_ready[0], rf_we);
        end
        src_valid = '0;
        tick();
        cmp_cnt++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 16'h3C00 || rf_wsrc !== 2'd0) begin
            mis_cnt++;
            $display("FAIL single_write got we=%b a=%0d d=%h s=%0d exp 1/5/3c00/0",
                     rf_we, rf_waddr, rf_wdata, rf_wsrc);
        end
        tick();
        cmp_cnt++;
        if (rf_we !== 1'b0) begin
            mis_cnt++;
            $display("FAIL single_idle got we=%b exp 0", rf_we);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        src_valid = 3'b111;
        for (int i = 0; i < N; i++) set_src(i, 5'($urandom_range(1, 31)), DW'($urandom));
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++)
                if (acc[i]) set_src(i, 5'($urandom_range(1, 31)), DW'($urandom));
            tick();
            cmp_cnt++;
            if (obs_ready !== exp_ready) begin
                mis_cnt++;
                $display("FAIL rr_ready c=%0d got %b exp %b", c, obs_ready, exp_ready);
            end
            if (c >= 1) begin
                cmp_cnt++;
                if (rf_we !== 1'b1 || rf_wsrc !== SW'((c - 1) % N) || rf_wdata !== exp_wdata) begin
                    mis_cnt++;
                    $display("FAIL rr_seq c=%0d got we=%b s=%0d d=%h exp 1/%0d/%h",
                             c, rf_we, rf_wsrc, rf_wdata, (c - 1) % N, exp_wdata);
                end
            end
        end
        src_valid = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        src_valid = 3'b011;
        set_src(0, 5'd7, 16'hAAAA);
        set_src(1, 5'd9, 16'hBBBB);
        tick();
        src_valid = 3'b010;
        set_src(1, 5'd11, 16'hCCCC);
        tick();
        cmp_cnt++;
        if (obs_ready[1] !== 1'b0 || obs_ready[0] !== 1'b1) begin
            mis_cnt++;
            $display("FAIL bp_stall got ready=%b exp x01", obs_ready);
        end
        cmp_cnt++;
        if (rf_we !== 1'b1 || rf_wsrc !== 2'd0 || rf_waddr !== 5'd7 || rf_wdata !== 16'hAAAA) begin
            mis_cnt++;
            $display("FAIL bp_w0 got we=%b s=%0d a=%0d d=%h exp 1/0/7/aaaa", rf_we, rf_wsrc, rf_waddr, rf_wdata);
        end
        tick();
        cmp_cnt++;
        if (obs_ready[1] !== 1'b1) begin
            mis_cnt++;
            $display("FAIL bp_release got ready1=%b exp 1", obs_ready[1]);
        end
        cmp_cnt++;
        if (rf_wsrc !== 2'd1 || rf_waddr !== 5'd9 || rf_wdata !== 16'hBBBB) begin
            mis_cnt++;
            $display("FAIL bp_w1 got s=%0d a=%0d d=%h exp 1/9/bbbb", rf_wsrc, rf_waddr, rf_wdata);
        end
        src_valid = '0;
        tick();
        cmp_cnt++;
        if (rf_we !== 1'b1 || rf_wsrc !== 2'd1 || rf_waddr !== 5'd11 || rf_wdata !== 16'hCCCC) begin
            mis_cnt++;
            $display("FAIL bp_w1b got we=%b s=%0d a=%0d d=%h exp 1/1/11/cccc", rf_we, rf_wsrc, rf_waddr, rf_wdata);
        end
        tick();
        cmp_cnt++;
        if (rf_we !== 1'b0) begin
            mis_cnt++;
            $display("FAIL bp_drain got we=%b exp 0", rf_we);
        end
    endtask

    task automatic test_zero_drop();
        src_valid = 3'b100;
        set_src(2, 5'd0, 16'hFFFF);
        tick();
        cmp_cnt++;
        if (obs_ready[2] !== 1'b1 || obs_busy !== 1'b0) begin
            mis_cnt++;
            $display("FAIL zero_hs got ready2=%b busy=%b exp 1/0", obs_ready[2], obs_busy);
        end
        src_valid = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            cmp_cnt++;
            if (rf_we !== 1'b0 || obs_busy !== 1'b0) begin
                mis_cnt++;
                $display("FAIL zero_nowrite c=%0d got we=%b busy=%b exp 0/0", c, rf_we, obs_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        src_valid = 3'b111;
        for (int i = 0; i < N; i++) set_src(i, 5'(20 + i), DW'(16'h5000 + i));
        tick();
        rst_n = 1'b0;
        tick();
        cmp_cnt++;
        if (obs_busy !== 1'b1 || rf_we !== 1'b0) begin
            mis_cnt++;
            $display("FAIL rmid_edge got busy=%b we=%b exp 1/0", obs_busy, rf_we);
        end
        rst_n     = 1'b1;
        src_valid = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            cmp_cnt++;
            if (rf_we !== 1'b0 || obs_busy !== 1'b0) begin
                mis_cnt++;
                $display("FAIL rmid_after c=%0d got we=%b busy=%b exp 0/0", c, rf_we, obs_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] || acc[i]) begin
                    src_valid[i] = ($urandom_range(0, 2) != 0);
                    rand_beat(i);
                end
            end
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
            cmp_cnt++;
            if (obs_ready !== exp_ready || obs_busy !== exp_busy) begin
                mis_cnt++;
                $display("FAIL rnd_ready cyc=%0d got r=%b b=%b exp r=%b b=%b",
                         cyc, obs_ready, obs_busy, exp_ready, exp_busy);
            end
            cmp_cnt++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata || rf_wsrc !== exp_wsrc) begin
                mis_cnt++;
                $display("FAIL rnd_write cyc=%0d got we=%b a=%0d d=%h s=%0d exp we=%b a=%0d d=%h s=%0d",
                         cyc, rf_we, rf_waddr, rf_wdata, rf_wsrc, exp_we, exp_waddr, exp_wdata, exp_wsrc);
            end
        end
        rst_n     = 1'b1;
        src_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_zero_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
